// File: rtl/cb_config_loader_if.sv
// Handshake and configuration-bus bundle between a bitstream source and the
// connection-box configuration loader.
interface cb_config_loader_if #(
    parameter int unsigned CFG_WIDTH = 35
);
    logic                 cfg_start;
    logic                 cfg_valid;
    logic                 cfg_bit;
    logic                 cfg_ready;
    logic                 cfg_busy;
    logic                 cfg_done;
    logic                 cfg_error;
    logic                 sram_valid;
    logic [CFG_WIDTH-1:0] sram_out;

    modport master (
        output cfg_start, cfg_valid, cfg_bit,
        input  cfg_ready, cfg_busy, cfg_done, cfg_error, sram_valid, sram_out
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit,
        output cfg_ready, cfg_busy, cfg_done, cfg_error, sram_valid, sram_out
    );
endinterface

// File: rtl/cb_config_loader.sv
// Bit-serial configuration loader for one connection box: shifts in a frame
// MSB first, checks an even-parity trailer, and commits only good frames.
module cb_config_loader #(
    parameter int unsigned CFG_WIDTH = 35,
    parameter int unsigned CNT_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    cb_config_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        COMMIT,
        ERROR
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_WIDTH - 1);

    state_t               state_q;
    logic [CFG_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 svalid_q;
    logic [CFG_WIDTH-1:0] sram_q;
    logic                 accept;

    assign accept = bus.cfg_valid && ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            svalid_q <= 1'b0;
            sram_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cfg_start) begin
                        state_q <= SHIFT;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        error_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // A restart wins over a bit offered in the same cycle.
                    if (bus.cfg_start) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        error_q <= 1'b0;
                    end else if (accept) begin
                        shift_q <= {shift_q[CFG_WIDTH-2:0], bus.cfg_bit};
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bus.cfg_start) begin
                        state_q <= SHIFT;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        error_q <= 1'b0;
                    end else if (accept) begin
                        ready_q <= 1'b0;
                        if ((^shift_q ^ bus.cfg_bit) == 1'b0) begin
                            state_q <= COMMIT;
                        end else begin
                            state_q <= ERROR;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    sram_q   <= shift_q;
                    svalid_q <= 1'b1;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                ERROR: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready  = ready_q;
    assign bus.cfg_busy   = busy_q;
    assign bus.cfg_done   = done_q;
    assign bus.cfg_error  = error_q;
    assign bus.sram_valid = svalid_q;
    assign bus.sram_out   = sram_q;

endmodule
